// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mult_pkg;

  // Controller states: wait for operands, iterate shift-add steps, hold the product.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mult_state_e;

endpackage

// File: rtl/rca.sv
// N-bit ripple-carry adder built from full-adder cells.
module rca #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  assign carry[0] = cin_i;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned multiplier: one shift-add step per cycle, fixed N-cycle latency,
// valid/ready handshakes on both operand and product sides.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P
);

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] LastStep = CntW'(N - 1);

  mult_state_e     state_q;
  logic [N-1:0]    mcand_q;
  logic [2*N-1:0]  acc_q;
  logic [2*N-1:0]  acc_d;
  logic [CntW-1:0] cnt_q;
  logic            out_valid_q;

  logic [N-1:0]    addend;
  logic [N-1:0]    sum;
  logic            cout;

  // Add the multiplicand to the high half only when the current multiplier bit is set.
  always_comb begin
    addend = acc_q[0] ? mcand_q : '0;
  end

  rca #(
    .N(N)
  ) u_rca (
    .a_i   (acc_q[2*N-1:N]),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(cout)
  );

  // Shift {carry-out, sum, low half} right by one; the consumed multiplier bit falls off.
  always_comb begin
    acc_d = {cout, sum, acc_q[N-1:1]};
  end

  // Controller FSM with registered datapath and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q <= A;
            acc_q   <= {{N{1'b0}}, B};
            cnt_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastStep) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready depends on state only, so no combinational path from either handshake input.
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  assign out_valid = out_valid_q;
  assign P         = acc_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and random checks of seq_shift_add_mult (N = 4) with a product scoreboard.
module tb_seq_shift_add_mult;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] P;

  int tests;
  int fails;
  logic [2*N-1:0] sb_q[$];

  seq_shift_add_mult #(
    .N(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P        (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] ea;
    logic [2*N-1:0] eb;
    ea = {{N{1'b0}}, a};
    eb = {{N{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [2*N-1:0] sb_pop();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  // One transaction: accept, measure latency, optional backpressure, handshake.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
    int lat;
    logic [2*N-1:0] exp;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ready_before_op", 32'(in_ready), 32'd1);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    sb_q.push_back(ref_mul(a, b));
    #1;
    in_valid = 1'b0;
    A        = ~a;
    B        = ~b;
    check("busy_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'(N));
    exp = sb_pop();
    check("product", 32'(P), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(P), 32'(exp));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_dropped", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_p_held", 32'(P), 32'(exp));
  endtask

  initial begin
    int accepts;
    int results;
    int last_out;
    logic rdy;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(P), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Max operands, zero operand, mixed
    do_op(4'd15, 4'd15, 0);
    do_op(4'd0, 4'd9, 0);
    do_op(4'd13, 4'd11, 0);

    // Backpressure for 10 cycles
    do_op(4'd7, 4'd6, 10);

    // Reset during step 2 of 9*9
    A         = 4'd9;
    B         = 4'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    sb_q.push_back(ref_mul(4'd9, 4'd9));
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_p", 32'(P), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    do_op(4'd3, 4'd5, 0);

    // Back-to-back with in_valid held high and operands changing every cycle
    accepts   = 0;
    results   = 0;
    last_out  = -1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      A   = ra;
      B   = rb;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb_q.push_back(ref_mul(ra, rb));
        accepts++;
      end
      #1;
      if (out_valid) begin
        check("b2b_product", 32'(P), 32'(sb_pop()));
        if (last_out >= 0) check("b2b_spacing", 32'(cyc - last_out), 32'(N + 2));
        last_out = cyc;
        results++;
      end
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        check("b2b_drain_product", 32'(P), 32'(sb_pop()));
        results++;
      end
    end
    check("b2b_count", 32'(results), 32'(accepts));
    check("b2b_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
